// File: rtl/ps2_keyboard_tx_if.sv
// Producer-side byte handshake into the PS/2 keyboard transmitter.
// Ports: tx_data (scan code), tx_valid (producer offers), tx_ready (FIFO not full).
// master = byte producer, slave = transmitter.
interface ps2_keyboard_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 transmitter: queued scan-code bytes sent as 11-bit frames (start, 8 data LSB first, odd parity, stop).
// Latency: byte pushed into an empty FIFO at edge E0 shows its start bit after E0+1; frame is 22*CLK_DIV clocks.
// Backpressure: tx_ready = !full from the registered count; ports clk, clrn, tx (slave), ps2_clk, ps2_data, busy, fifo_count.
module ps2_keyboard_tx #(
    parameter int CLK_DIV  = 8,
    parameter int FIFO_AW  = 2,
    parameter int GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              clrn,
    ps2_keyboard_tx_if.slave  tx,
    output logic              ps2_clk,
    output logic              ps2_data,
    output logic              busy,
    output logic [FIFO_AW:0]  fifo_count
);
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int BIT_CYC = 2 * CLK_DIV;
    localparam int GAP_CYC = GAP_BITS * BIT_CYC;
    localparam int CNT_MAX = (GAP_CYC > BIT_CYC) ? GAP_CYC : BIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    // ---------------- FIFO ----------------
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               push, pop;
    logic [7:0]         head;

    // Ready looks only at the registered count, so a same-cycle pop never raises it.
    assign tx.tx_ready = (count_q != FULL_CNT);
    assign push        = tx.tx_valid && tx.tx_ready;
    assign head        = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx.tx_data;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- Frame FSM ----------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d, div_inc;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [10:0]      shift_q, shift_d;
    logic             ps2_clk_q, ps2_clk_d;
    logic             ps2_data_q, ps2_data_d;

    assign div_inc = div_q + 1'b1;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '1;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        ps2_clk_d  = ps2_clk_q;
        ps2_data_d = ps2_data_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (count_q != '0) begin
                    pop        = 1'b1;
                    // bit0 = start, bits1..8 = data, bit9 = odd parity, bit10 = stop
                    shift_d    = {1'b1, ~^head, head, 1'b0};
                    ps2_data_d = 1'b0;
                    div_d      = '0;
                    bit_idx_d  = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (div_q == BIT_LAST) begin
                    // Bit boundary: clock returns high together with the new data bit,
                    // so data never moves while the clock is low.
                    div_d     = '0;
                    ps2_clk_d = 1'b1;
                    if (bit_idx_q == 4'd10) begin
                        ps2_data_d = 1'b1;
                        state_d    = (GAP_BITS == 0) ? IDLE : GAP;
                    end else begin
                        bit_idx_d  = bit_idx_q + 1'b1;
                        shift_d    = {1'b1, shift_q[10:1]};
                        ps2_data_d = shift_q[1];
                    end
                end else begin
                    div_d     = div_inc;
                    // Register the level for the next divider value: low in the second half.
                    ps2_clk_d = (div_inc < HALF);
                end
            end
            GAP: begin
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (div_q == GAP_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ps2_clk    = ps2_clk_q;
    assign ps2_data   = ps2_data_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;
endmodule

// File: tb/tb_ps2_keyboard_tx.sv
module tb_ps2_keyboard_tx;
    localparam int T      = 4;
    localparam int FRAME  = 22 * T;              // 88 clocks per frame
    localparam int PERIOD = FRAME + 2 * 2 * T + 1; // start-to-start for back-to-back frames

    logic       clk  = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk, ps2_data, busy;
    logic [2:0] fifo_count;

    ps2_keyboard_tx_if tx_if();

    ps2_keyboard_tx #(.CLK_DIV(T), .FIFO_AW(2), .GAP_BITS(2)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .tx         (tx_if),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         par_q[$];
    int         starts[$];
    int         frames_done = 0;
    int         bitcnt = 0;
    bit         in_frame = 0;
    bit         wait_end = 0;
    logic       prev_clk = 1'b1;
    logic       prev_data = 1'b1;
    int         cur_start = 0;
    int         last_acc = 0;
    logic [10:0] bits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Line monitor: decodes frames on ps2_clk falling edges and scores them.
    always @(negedge clk) begin
        if (!clrn) begin
            bitcnt   = 0;
            in_frame = 0;
            wait_end = 0;
            prev_clk = 1'b1;
            prev_data = 1'b1;
        end else begin
            if (!in_frame && prev_data && !ps2_data) begin
                in_frame  = 1;
                cur_start = cyc;
                starts.push_back(cyc);
            end
            if (!prev_clk && !ps2_clk)
                chk("data_stable_while_clk_low", ps2_data, prev_data);
            if (prev_clk && !ps2_clk) begin
                if (bitcnt == 0) chk("first_fall_offset", cyc - cur_start, T);
                bits[bitcnt] = ps2_data;
                bitcnt++;
                if (bitcnt == 11) begin
                    logic [7:0] e;
                    chk("start_bit", bits[0], 0);
                    chk("stop_bit", bits[10], 1);
                    chk("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("frame_data", bits[8:1], e);
                        chk("frame_parity", bits[9], ~^e);
                    end
                    par_q.push_back(bits[9]);
                    frames_done++;
                    bitcnt   = 0;
                    wait_end = 1;
                end
            end
            if (wait_end && ps2_clk) begin
                chk("frame_length", cyc - cur_start, FRAME);
                wait_end = 0;
                in_frame = 0;
            end
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
        end
    end

    task automatic push(input logic [7:0] d, input bit expect_ready);
        @(negedge clk);
        chk("tx_ready", tx_if.tx_ready, expect_ready);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        if (expect_ready) begin
            exp_q.push_back(d);
            last_acc = cyc + 1;
        end
    endtask

    task automatic push_wait(input logic [7:0] d, output int waited);
        waited = 0;
        @(negedge clk);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        while (tx_if.tx_ready !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk("push_wait_timeout", waited < 400, 1);
        exp_q.push_back(d);
    endtask

    task automatic release_valid();
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames_done < n && k < 3000) begin @(negedge clk); k++; end
        chk("wait_frames_timeout", frames_done >= n, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 3000) begin @(negedge clk); k++; end
        chk("wait_idle_timeout", busy, 0);
    endtask

    task automatic wait_cyc(input int target);
        int k = 0;
        while (cyc < target && k < 3000) begin @(negedge clk); k++; end
        chk("wait_cyc_timeout", cyc >= target, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: no finish by time limit, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, i, s, idle_bad, fr;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ps2_clk", ps2_clk, 1);
        chk("rst_ps2_data", ps2_data, 1);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_tx_ready", tx_if.tx_ready, 1);
        chk("rst_busy", busy, 0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 1C: latency, frame, busy release after gap + idle cycle
        push(8'h1C, 1);
        release_valid();
        wait_frames(1);
        chk("start_latency", starts[0] - last_acc, 1);
        wait_cyc(starts[0] + PERIOD - 2);
        chk("busy_in_gap", busy, 1);
        @(negedge clk);
        chk("busy_after_gap", busy, 0);

        // F0 then 00 back-to-back: parity 1,1 and 17 idle clocks between frames
        push(8'hF0, 1);
        push(8'h00, 1);
        release_valid();
        wait_frames(3);
        chk("parity_F0", par_q[1], 1);
        chk("parity_00", par_q[2], 1);
        chk("idle_gap_clocks", starts[2] - starts[1] - FRAME, 2 * 2 * T + 1);
        wait_idle();

        // FIFO full: 6 pushes while the first frame is on the wire
        push(8'h11, 1);
        release_valid();
        repeat (3) @(negedge clk);
        push(8'h22, 1);
        push(8'h33, 1);
        push(8'h44, 1);
        push(8'h55, 1);
        push(8'h66, 0);
        chk("fifo_count_full", fifo_count, 4);
        push_wait(8'h66, w);
        chk("full_hold_66", w > 50, 1);
        push_wait(8'h77, w);
        chk("full_hold_77", w > 50, 1);
        release_valid();
        wait_idle();
        chk("full_frames_done", frames_done, 10);

        // Push and pop on the same edge with two bytes queued
        i = starts.size();
        push(8'hA1, 1);
        release_valid();
        repeat (3) @(negedge clk);
        push(8'hA2, 1);
        push(8'hA3, 1);
        release_valid();
        s = starts[i];
        wait_cyc(s + PERIOD - 2);
        chk("pushpop_count_before", fifo_count, 2);
        push(8'hA4, 1);
        release_valid();
        chk("pushpop_count_after", fifo_count, 2);
        wait_idle();
        chk("pushpop_pop_timing", starts[i + 1] - s, PERIOD);

        // Reset mid-frame with three bytes queued
        push(8'hB1, 1);
        release_valid();
        repeat (3) @(negedge clk);
        push(8'hB2, 1);
        push(8'hB3, 1);
        push(8'hB4, 1);
        release_valid();
        begin
            int k = 0;
            while (bitcnt < 6 && k < 500) begin @(negedge clk); k++; end
            chk("reach_bit5_timeout", bitcnt >= 6, 1);
        end
        #2 clrn = 1'b0;
        #1;
        chk("midrst_ps2_clk", ps2_clk, 1);
        chk("midrst_ps2_data", ps2_data, 1);
        chk("midrst_fifo_count", fifo_count, 0);
        chk("midrst_tx_ready", tx_if.tx_ready, 1);
        chk("midrst_busy", busy, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        fr = frames_done;
        idle_bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (!(ps2_clk === 1'b1 && ps2_data === 1'b1 && busy === 1'b0 && fifo_count === 3'd0))
                idle_bad++;
        end
        chk("idle_after_reset", idle_bad, 0);
        chk("no_frame_after_reset", frames_done, fr);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
